// File: rtl/bster_pkg.sv
// Shared types and helpers for the bster command front-end.
// Channel IDs are carried as the narrowest vector that can hold NB_CHANNELS-1.
package bster_pkg;

  localparam int CMD_WIDTH_DEF = 128;
  localparam int STS_WIDTH_DEF = 8;
  localparam int MAX_CHANNELS  = 16;

  // A single-channel build still needs a one-bit ID field.
  function automatic int id_width(input int nb_channels);
    return (nb_channels > 1) ? $clog2(nb_channels) : 1;
  endfunction

  typedef logic [$clog2(MAX_CHANNELS)-1:0] chan_id_t;

endpackage

// File: rtl/bster_id_fifo.sv
// In-order queue of originating channel IDs for commands sent to the engine.
// Head is the channel that owns the next completion/status pair.
module bster_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is not reset; entries are only read once count covers them,
  // so reset only has to clear pointers and count.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bster_cmd_mux.sv
// Round-robin command mux in front of the bster engine, with in-order
// routing of engine completion/status back to the issuing channel.
module bster_cmd_mux
  import bster_pkg::*;
#(
  parameter int NB_CHANNELS = 4,
  parameter int CMD_WIDTH   = CMD_WIDTH_DEF,
  parameter int STS_WIDTH   = STS_WIDTH_DEF,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_CHANNELS-1:0]           chan_en,
  input  logic                             err_clear,
  input  logic [NB_CHANNELS-1:0]           s_cmd_tvalid,
  output logic [NB_CHANNELS-1:0]           s_cmd_tready,
  input  logic [NB_CHANNELS*CMD_WIDTH-1:0] s_cmd_tdata,
  output logic                             m_cmd_tvalid,
  input  logic                             m_cmd_tready,
  output logic [CMD_WIDTH-1:0]             m_cmd_tdata,
  input  logic                             s_cpl_tvalid,
  output logic                             s_cpl_tready,
  input  logic [CMD_WIDTH-1:0]             s_cpl_tdata,
  input  logic                             s_sts_tvalid,
  output logic                             s_sts_tready,
  input  logic [STS_WIDTH-1:0]             s_sts_tdata,
  output logic [NB_CHANNELS-1:0]           m_cpl_tvalid,
  input  logic [NB_CHANNELS-1:0]           m_cpl_tready,
  output logic [CMD_WIDTH-1:0]             m_cpl_tdata,
  output logic [NB_CHANNELS-1:0]           m_sts_tvalid,
  input  logic [NB_CHANNELS-1:0]           m_sts_tready,
  output logic [STS_WIDTH-1:0]             m_sts_tdata,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding,
  output logic                             err_spurious
);

  localparam int ID_W  = id_width(NB_CHANNELS);
  localparam int OUT_W = $clog2(TAG_DEPTH + 1);

  logic [NB_CHANNELS-1:0] elig;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        win_idx;
  logic                   win_found;
  logic                   grant;
  logic [ID_W-1:0]        head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   cpl_done;
  logic                   sts_done;
  logic                   cpl_hs;
  logic                   sts_hs;
  logic                   retire;

  assign elig = s_cmd_tvalid & chan_en;

  // NOTE: combinational blocks use blocking assignments with a default first,
  // so every path assigns every output and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NB_CHANNELS; off++) begin
      int idx;
      idx = (int'(rr_ptr) + off) % NB_CHANNELS;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  // The full test uses the registered count, so a retire this cycle cannot
  // make room for a grant in the same cycle.
  assign grant = win_found && (!m_cmd_tvalid || m_cmd_tready) && !fifo_full;

  always_comb begin
    s_cmd_tready = '0;
    if (grant) s_cmd_tready[win_idx] = 1'b1;
  end

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr       <= '0;
      m_cmd_tvalid <= 1'b0;
      m_cmd_tdata  <= '0;
    end else if (grant) begin
      rr_ptr       <= (win_idx == ID_W'(NB_CHANNELS - 1)) ? '0 : win_idx + 1'b1;
      m_cmd_tvalid <= 1'b1;
      m_cmd_tdata  <= s_cmd_tdata[int'(win_idx)*CMD_WIDTH +: CMD_WIDTH];
    end else if (m_cmd_tready) begin
      m_cmd_tvalid <= 1'b0;
    end
  end

  bster_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH),
    .CW    (OUT_W)
  ) u_id_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (grant),
    .push_data (win_idx),
    .pop       (retire),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (outstanding)
  );

  assign m_cpl_tdata = s_cpl_tdata;
  assign m_sts_tdata = s_sts_tdata;

  always_comb begin
    m_cpl_tvalid = '0;
    m_sts_tvalid = '0;
    s_cpl_tready = 1'b0;
    s_sts_tready = 1'b0;
    if (!fifo_empty) begin
      m_cpl_tvalid[head] = s_cpl_tvalid && !cpl_done;
      m_sts_tvalid[head] = s_sts_tvalid && !sts_done;
      s_cpl_tready       = m_cpl_tready[head] && !cpl_done;
      s_sts_tready       = m_sts_tready[head] && !sts_done;
    end
  end

  assign cpl_hs = s_cpl_tvalid && s_cpl_tready;
  assign sts_hs = s_sts_tvalid && s_sts_tready;
  assign retire = (cpl_done || cpl_hs) && (sts_done || sts_hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cpl_done     <= 1'b0;
      sts_done     <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (retire) begin
        cpl_done <= 1'b0;
        sts_done <= 1'b0;
      end else begin
        cpl_done <= cpl_done || cpl_hs;
        sts_done <= sts_done || sts_hs;
      end
      // Set takes priority over clear.
      if (fifo_empty && (s_cpl_tvalid || s_sts_tvalid)) err_spurious <= 1'b1;
      else if (err_clear)                               err_spurious <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bster_cmd_mux.sv
// Directed bench for bster_cmd_mux: arbitration order, tag limit, in-order
// return routing, channel masking and spurious-return error.
module tb_bster_cmd_mux;
  import bster_pkg::*;

  localparam int NB  = 4;
  localparam int CW  = 128;
  localparam int SW  = 8;
  localparam int TD  = 8;
  localparam int OW  = $clog2(TD + 1);

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NB-1:0]     chan_en;
  logic              err_clear;
  logic [NB-1:0]     s_cmd_tvalid;
  logic [NB-1:0]     s_cmd_tready;
  logic [NB*CW-1:0]  s_cmd_tdata;
  logic              m_cmd_tvalid;
  logic              m_cmd_tready;
  logic [CW-1:0]     m_cmd_tdata;
  logic              s_cpl_tvalid;
  logic              s_cpl_tready;
  logic [CW-1:0]     s_cpl_tdata;
  logic              s_sts_tvalid;
  logic              s_sts_tready;
  logic [SW-1:0]     s_sts_tdata;
  logic [NB-1:0]     m_cpl_tvalid;
  logic [NB-1:0]     m_cpl_tready;
  logic [CW-1:0]     m_cpl_tdata;
  logic [NB-1:0]     m_sts_tvalid;
  logic [NB-1:0]     m_sts_tready;
  logic [SW-1:0]     m_sts_tdata;
  logic [OW-1:0]     outstanding;
  logic              err_spurious;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  bster_cmd_mux #(
    .NB_CHANNELS (NB),
    .CMD_WIDTH   (CW),
    .STS_WIDTH   (SW),
    .TAG_DEPTH   (TD)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .chan_en      (chan_en),
    .err_clear    (err_clear),
    .s_cmd_tvalid (s_cmd_tvalid),
    .s_cmd_tready (s_cmd_tready),
    .s_cmd_tdata  (s_cmd_tdata),
    .m_cmd_tvalid (m_cmd_tvalid),
    .m_cmd_tready (m_cmd_tready),
    .m_cmd_tdata  (m_cmd_tdata),
    .s_cpl_tvalid (s_cpl_tvalid),
    .s_cpl_tready (s_cpl_tready),
    .s_cpl_tdata  (s_cpl_tdata),
    .s_sts_tvalid (s_sts_tvalid),
    .s_sts_tready (s_sts_tready),
    .s_sts_tdata  (s_sts_tdata),
    .m_cpl_tvalid (m_cpl_tvalid),
    .m_cpl_tready (m_cpl_tready),
    .m_cpl_tdata  (m_cpl_tdata),
    .m_sts_tvalid (m_sts_tvalid),
    .m_sts_tready (m_sts_tready),
    .m_sts_tdata  (m_sts_tdata),
    .outstanding  (outstanding),
    .err_spurious (err_spurious)
  );

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [CW-1:0] cmd_word(input int ch);
    return CW'(32'h100 + ch);
  endfunction

  function automatic logic [NB-1:0] onehot(input int ch);
    logic [NB-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    #12;
    aresetn = 1'b1;
    #1;
  endtask

  task automatic drain(input int n, input chan_id_t heads[$]);
    s_cpl_tvalid = 1'b1;
    s_sts_tvalid = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_cpl_tdata = CW'(32'hC00 + k);
      #1;
      check($sformatf("drain_cpl_route%0d", k), CW'(m_cpl_tvalid), CW'(onehot(int'(heads[k]))));
      check($sformatf("drain_sts_route%0d", k), CW'(m_sts_tvalid), CW'(onehot(int'(heads[k]))));
      tick();
    end
    s_cpl_tvalid = 1'b0;
    s_sts_tvalid = 1'b0;
  endtask

  initial begin
    chan_id_t heads[$];
    chan_id_t order3[3];
    aresetn      = 1'b0;
    chan_en      = '1;
    err_clear    = 1'b0;
    s_cmd_tvalid = '0;
    m_cmd_tready = 1'b1;
    s_cpl_tvalid = 1'b0;
    s_cpl_tdata  = '0;
    s_sts_tvalid = 1'b0;
    s_sts_tdata  = '0;
    m_cpl_tready = '1;
    m_sts_tready = '1;
    for (int i = 0; i < NB; i++) s_cmd_tdata[i*CW +: CW] = cmd_word(i);
    do_reset();

    check("rst_m_cmd_tvalid", CW'(m_cmd_tvalid), '0);
    check("rst_m_cmd_tdata", m_cmd_tdata, '0);
    check("rst_outstanding", CW'(outstanding), '0);
    check("rst_err", CW'(err_spurious), '0);
    check("rst_s_cpl_tready", CW'(s_cpl_tready), '0);

    // Round robin with every channel requesting; fills the tag queue.
    s_cmd_tvalid = '1;
    #1;
    for (int k = 0; k < TD; k++) begin
      check($sformatf("rr_ready%0d", k), CW'(s_cmd_tready), CW'(onehot(k % NB)));
      tick();
      check($sformatf("rr_valid%0d", k), CW'(m_cmd_tvalid), CW'(1));
      check($sformatf("rr_data%0d", k), m_cmd_tdata, cmd_word(k % NB));
      check($sformatf("rr_outst%0d", k), CW'(outstanding), CW'(k + 1));
    end
    check("full_stall_ready", CW'(s_cmd_tready), '0);
    tick();
    check("full_stall_outst", CW'(outstanding), CW'(TD));
    check("full_m_cmd_idle", CW'(m_cmd_tvalid), '0);

    // One retire; the freed slot is usable only from the next cycle.
    s_cpl_tvalid = 1'b1;
    s_sts_tvalid = 1'b1;
    s_cpl_tdata  = CW'(32'hABC);
    #1;
    check("retire_cpl_route", CW'(m_cpl_tvalid), CW'(onehot(0)));
    check("retire_cpl_data", m_cpl_tdata, CW'(32'hABC));
    check("retire_same_cycle_ready", CW'(s_cmd_tready), '0);
    tick();
    s_cpl_tvalid = 1'b0;
    s_sts_tvalid = 1'b0;
    check("retire_outst", CW'(outstanding), CW'(TD - 1));
    check("ninth_ready", CW'(s_cmd_tready), CW'(onehot(0)));
    tick();
    s_cmd_tvalid = '0;
    check("ninth_outst", CW'(outstanding), CW'(TD));
    check("ninth_data", m_cmd_tdata, cmd_word(0));

    heads = '{1, 2, 3, 0, 1, 2, 3, 0};
    drain(TD, heads);
    check("drain_outst", CW'(outstanding), '0);

    // Commands from 2, 0, 3; completions wait for status to retire each head.
    order3 = '{2, 0, 3};
    for (int j = 0; j < 3; j++) begin
      s_cmd_tvalid = onehot(int'(order3[j]));
      #1;
      check($sformatf("ord_ready%0d", j), CW'(s_cmd_tready), CW'(onehot(int'(order3[j]))));
      tick();
    end
    s_cmd_tvalid = '0;
    check("ord_outst", CW'(outstanding), CW'(3));
    s_cpl_tvalid = 1'b1;
    s_sts_tdata  = 8'h5A;
    for (int j = 0; j < 3; j++) begin
      s_cpl_tdata = CW'(32'hA00 + int'(order3[j]));
      #1;
      check($sformatf("ord_cpl_route%0d", j), CW'(m_cpl_tvalid), CW'(onehot(int'(order3[j]))));
      check($sformatf("ord_cpl_data%0d", j), m_cpl_tdata, CW'(32'hA00 + int'(order3[j])));
      tick();
      if (j < 2) s_cpl_tdata = CW'(32'hA00 + int'(order3[j+1]));
      else       s_cpl_tvalid = 1'b0;
      #1;
      check($sformatf("ord_cpl_blocked%0d", j), CW'(m_cpl_tvalid), '0);
      check($sformatf("ord_cpl_tready_lo%0d", j), CW'(s_cpl_tready), '0);
      s_sts_tvalid = 1'b1;
      #1;
      check($sformatf("ord_sts_route%0d", j), CW'(m_sts_tvalid), CW'(onehot(int'(order3[j]))));
      check($sformatf("ord_sts_data%0d", j), CW'(m_sts_tdata), CW'(8'h5A));
      tick();
      s_sts_tvalid = 1'b0;
      check($sformatf("ord_outst%0d", j), CW'(outstanding), CW'(2 - j));
    end

    // Channels 1 and 2 outstanding; single-cycle retire of head 1.
    s_cmd_tvalid = 4'b0110;
    tick();
    tick();
    s_cmd_tvalid = '0;
    s_cpl_tvalid = 1'b1;
    s_sts_tvalid = 1'b1;
    #1;
    check("same_cpl_route", CW'(m_cpl_tvalid), CW'(onehot(1)));
    check("same_sts_route", CW'(m_sts_tvalid), CW'(onehot(1)));
    check("same_outst_before", CW'(outstanding), CW'(2));
    tick();
    check("same_outst_after", CW'(outstanding), CW'(1));
    check("same_next_head", CW'(m_cpl_tvalid), CW'(onehot(2)));
    tick();
    s_cpl_tvalid = 1'b0;
    s_sts_tvalid = 1'b0;
    check("same_drained", CW'(outstanding), '0);

    // Channel 2 masked out.
    do_reset();
    chan_en      = 4'b1011;
    s_cmd_tvalid = '1;
    heads = '{0, 1, 3, 0};
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("mask_ready%0d", k), CW'(s_cmd_tready), CW'(onehot(int'(heads[k]))));
      tick();
      check($sformatf("mask_data%0d", k), m_cmd_tdata, cmd_word(int'(heads[k])));
    end
    s_cmd_tvalid = '0;
    chan_en      = '1;
    drain(4, heads);

    // Spurious status with nothing outstanding.
    s_sts_tvalid = 1'b1;
    #1;
    check("spur_sts_tready", CW'(s_sts_tready), '0);
    check("spur_sts_route", CW'(m_sts_tvalid), '0);
    tick();
    s_sts_tvalid = 1'b0;
    check("spur_err_set", CW'(err_spurious), CW'(1));
    tick();
    check("spur_err_sticky", CW'(err_spurious), CW'(1));
    err_clear    = 1'b1;
    s_cpl_tvalid = 1'b1;
    tick();
    s_cpl_tvalid = 1'b0;
    check("spur_set_wins", CW'(err_spurious), CW'(1));
    tick();
    err_clear = 1'b0;
    check("spur_err_cleared", CW'(err_spurious), '0);

    // Engine back-pressure holds the registered command.
    m_cmd_tready = 1'b0;
    s_cmd_tvalid = onehot(1);
    #1;
    check("bp_first_ready", CW'(s_cmd_tready), CW'(onehot(1)));
    tick();
    check("bp_hold_ready", CW'(s_cmd_tready), '0);
    tick();
    check("bp_hold_valid", CW'(m_cmd_tvalid), CW'(1));
    check("bp_hold_data", m_cmd_tdata, cmd_word(1));
    s_cmd_tvalid = '0;
    m_cmd_tready = 1'b1;
    tick();
    check("bp_release", CW'(m_cmd_tvalid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
